bus_reg_transfer: RTL

- Register-transfer controller that sits around the 4:1 shared-bus multiplexer.
- Upstream role: holds registers B, C, D and drives the mux select lines.
- Downstream role: captures the mux output back into a destination register.
- Sequences one source-to-destination transfer per request with a ready/valid handshake, and supports direct external loads of B/C/D.

---
 rtl/bus_reg_transfer_if.sv | 35 +++
 rtl/bus_reg_transfer.sv | 86 ++++++++
 2 files changed

// File: rtl/bus_reg_transfer_if.sv
// Handshake, load and shared-bus signals between the register-transfer
// controller and its environment (requester, external loader, 4:1 mux).
interface bus_reg_transfer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_src;
  logic [1:0]       req_dst;
  logic             load_en;
  logic [1:0]       load_dst;
  logic [WIDTH-1:0] load_data;
  logic             sel_x;
  logic             sel_y;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] reg_c;
  logic [WIDTH-1:0] reg_d;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] xfer_count;

  // Controller side.
  modport slave (
    input  req_valid, req_src, req_dst, load_en, load_dst, load_data, bus_in,
    output req_ready, sel_x, sel_y, reg_b, reg_c, reg_d, busy, done, xfer_count
  );

  // Environment side: requester, loader and the mux that closes the loop.
  modport master (
    output req_valid, req_src, req_dst, load_en, load_dst, load_data, bus_in,
    input  req_ready, sel_x, sel_y, reg_b, reg_c, reg_d, busy, done, xfer_count
  );
endinterface

// File: rtl/bus_reg_transfer.sv
// Register-transfer controller around a 4:1 shared-bus mux: holds B/C/D,
// drives the mux select and writes the mux output back to a destination.
module bus_reg_transfer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  bus_reg_transfer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       sel;
  logic [1:0]       dst_q;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] reg_c;
  logic [WIDTH-1:0] reg_d;
  logic             done;
  logic [CNT_W-1:0] xfer_count;

  // An external load in IDLE stalls the request rather than dropping it.
  assign bus.req_ready  = (state == IDLE) && !bus.load_en;
  assign bus.busy       = (state != IDLE);
  assign bus.sel_x      = sel[1];
  assign bus.sel_y      = sel[0];
  assign bus.reg_b      = reg_b;
  assign bus.reg_c      = reg_c;
  assign bus.reg_d      = reg_d;
  assign bus.done       = done;
  assign bus.xfer_count = xfer_count;

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; blocking would make results order-dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 2'b00;
      dst_q      <= 2'b00;
      reg_b      <= '0;
      reg_c      <= '0;
      reg_d      <= '0;
      done       <= 1'b0;
      xfer_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          sel <= 2'b00;
          if (bus.load_en) begin
            unique case (bus.load_dst)
              2'b01:   reg_b <= bus.load_data;
              2'b10:   reg_c <= bus.load_data;
              2'b11:   reg_d <= bus.load_data;
              default: ;
            endcase
          end else if (bus.req_valid) begin
            sel   <= bus.req_src;
            dst_q <= bus.req_dst;
            state <= SELECT;
          end
        end
        SELECT: state <= WRITE;
        WRITE: begin
          unique case (dst_q)
            2'b01:   reg_b <= bus.bus_in;
            2'b10:   reg_c <= bus.bus_in;
            2'b11:   reg_d <= bus.bus_in;
            default: ;
          endcase
          done <= 1'b1;
          if (xfer_count != '1) xfer_count <= xfer_count + 1'b1;
          sel   <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
